aes_serial_sequencer: RTL and testbench
=======================================

Name: aes_serial_sequencer

Overview:
Parallel-to-serial sequencer that drives one serial AES core (Encrypt or Decrypt, cs/miso/mosi/finished interface) on behalf of a single requester. It accepts a 128-bit text block and a key over a valid/ready handshake, shifts both into the core, waits for the core's finished flag, and shifts the 128-bit result back out. It returns the result over a valid/ready response channel. A watchdog flags a core that never finishes.

Parameters:
NK, 6, key length in 32-bit words (4/6/8); KEY_BITS = 32*NK
TIMEOUT, 1024, maximum clk cycles spent in WAIT before the error exit
CNT_W, 16, width of the internal bit/timeout counter; must hold max(128+KEY_BITS, TIMEOUT)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept a request
req_text  in  128  plaintext or ciphertext block
req_key  in  KEY_BITS  cipher key
resp_valid  out  1  result available
resp_ready  in  1  requester accepts result
resp_data  out  128  result block
resp_err  out  1  result invalid, core timed out
core_cs  out  1  chip select to core
core_miso  out  1  serial data to core
core_mosi  in  1  serial data from core
core_finished  in  1  core completion flag
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE, core_cs=0, core_miso=0, req_ready=0 during reset, resp_valid=0, resp_data=0, resp_err=0, busy=0, counter=0, shift registers=0.
- req_ready = (state==IDLE); combinational from state.
- resp_valid and resp_data are registered.
- IDLE:
  - On req_valid&&req_ready, latch {req_key,req_text} into a (128+KEY_BITS)-bit load shift register, counter=0, go to LOAD.
  - No request is accepted in any other state.
- LOAD:
  - core_cs=1.
  - core_miso = load_sr[0] in every LOAD cycle, so the first bit is present in the first LOAD cycle.
  - Each clk: shift load_sr right by 1, counter+1.
  - Bit order: text bit 0 first through text bit 127, then key bit 0 through key bit KEY_BITS-1.
  - After exactly 128+KEY_BITS LOAD cycles: core_cs=0, core_miso=0, counter=0, go to WAIT.
- WAIT:
  - core_cs=0.
  - If core_finished==1 is sampled: counter=0, go to READ.
  - Otherwise, when counter reaches TIMEOUT-1 (TIMEOUT cycles spent in WAIT): resp_err=1, resp_data=0, resp_valid=1, go to RESP.
  - core_finished takes priority over the timeout in the same cycle.
- READ:
  - core_cs=1 for exactly 128 cycles.
  - Each clk: rd_sr = {core_mosi, rd_sr[127:1]}, so the first bit received becomes bit 0.
  - In the 128th READ cycle: resp_data = completed rd_sr, resp_err=0, resp_valid=1, core_cs=0, go to RESP.
- RESP:
  - resp_valid held high and resp_data/resp_err stable until resp_valid&&resp_ready.
  - On that handshake, clear resp_valid and go to IDLE.
  - The next request can be accepted the cycle after the handshake; no back-to-back overlap.
- core_finished is ignored outside WAIT.
- core_mosi is ignored outside READ.
- Latency, request accept to resp_valid: 1 + (128+KEY_BITS) + W + 128 cycles, where W = WAIT cycles (1..TIMEOUT).
- Reset mid-operation: immediate return to the reset values above. core_cs drops asynchronously. Partial shift data is discarded and no response is produced.
- Counter never wraps: its range is bounded by the state exits above.

Test Plan:
- NK=6, real Encrypt core: key 000102030405060708090a0b0c0d0e0f1011121314151617, text 00112233445566778899aabbccddeeff -> resp_data=dda97ca4864cdfe06eaf70a0ec0d7191, resp_err=0, core_cs high for exactly 320 cycles in LOAD.
- NK=6, real Decrypt core: same key, text dda97ca4864cdfe06eaf70a0ec0d7191 -> resp_data=00112233445566778899aabbccddeeff.
- Stub core, finished never asserted, TIMEOUT=16 -> resp_valid after 1+320+16 cycles, resp_err=1, resp_data=0.
- Stub core returning alternating 1,0 bits, resp_ready held low 50 cycles -> resp_data=5555...5555 held stable and resp_valid high throughout; IDLE and req_ready=1 one cycle after resp_ready rises.
- req_valid held high continuously -> exactly one accept per transaction; req_ready=0 from LOAD through RESP.
- rst pulsed at LOAD bit 100 -> core_cs=0 and resp_valid=0 immediately; a new request then completes with the correct vector.

Source files
------------

// File: rtl/aes_serial_sequencer.sv
// Parallel-to-serial sequencer for a single serial AES core: loads text+key bit-serially,
// waits for the core to finish (with a watchdog), reads the 128-bit result back serially.
module aes_serial_sequencer #(
  parameter int unsigned NK      = 6,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [127:0]      req_text_i,
  input  logic [32*NK-1:0]  req_key_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [127:0]      resp_data_o,
  output logic              resp_err_o,
  output logic              core_cs_o,
  output logic              core_miso_o,
  input  logic              core_mosi_i,
  input  logic              core_finished_i,
  output logic              busy_o
);

  localparam int unsigned KeyBits  = 32 * NK;
  localparam int unsigned LoadBits = 128 + KeyBits;

  typedef enum logic [2:0] {StIdle, StLoad, StWait, StRead, StResp} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LoadBits-1:0]   load_sr_q, load_sr_d;
  logic [127:0]          rd_sr_q, rd_sr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [127:0]          resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      load_sr_q    <= '0;
      rd_sr_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      load_sr_q    <= load_sr_d;
      rd_sr_q      <= rd_sr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_sr_d    = load_sr_q;
    rd_sr_d      = rd_sr_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          // Text sits in the low bits so it leaves the shift register first, LSB first.
          load_sr_d = {req_key_i, req_text_i};
          cnt_d     = '0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        load_sr_d = load_sr_q >> 1;
        if (cnt_q == CNT_W'(LoadBits - 1)) begin
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWait: begin
        if (core_finished_i) begin
          cnt_d   = '0;
          state_d = StRead;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRead: begin
        rd_sr_d = {core_mosi_i, rd_sr_q[127:1]};
        if (cnt_q == CNT_W'(127)) begin
          resp_data_d  = rd_sr_d;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode straight from state so reset drops them asynchronously.
  assign req_ready_o  = (state_q == StIdle) && !rst;
  assign core_cs_o    = (state_q == StLoad) || (state_q == StRead);
  assign core_miso_o  = (state_q == StLoad) && load_sr_q[0];
  assign busy_o       = (state_q != StIdle);
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_aes_serial_sequencer.sv
// Directed bench for aes_serial_sequencer with a behavioural serial-core stub that captures
// the loaded bits and returns a chosen 128-bit word.
module tb_aes_serial_sequencer;

  localparam int unsigned NK = 6;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [127:0] req_text;
  logic [191:0] req_key;
  logic         resp_valid, resp_ready;
  logic [127:0] resp_data;
  logic         resp_err;
  logic         core_cs, core_miso, core_mosi, core_finished;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  // Stub core state
  logic [319:0] cap;
  logic [127:0] stub_out;
  int           ld_cnt, rd_idx;
  int           acc_cnt = 0;
  int           bad_ready;

  aes_serial_sequencer #(.NK(NK), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_text_i     (req_text),
    .req_key_i      (req_key),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_data_o    (resp_data),
    .resp_err_o     (resp_err),
    .core_cs_o      (core_cs),
    .core_miso_o    (core_miso),
    .core_mosi_i    (core_mosi),
    .core_finished_i(core_finished),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  assign core_mosi = (rd_idx < 128) ? stub_out[rd_idx[6:0]] : 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt <= 0;
      rd_idx <= 0;
    end else if (req_valid && req_ready) begin
      ld_cnt  <= 0;
      rd_idx  <= 0;
      acc_cnt <= acc_cnt + 1;
    end else if (core_cs) begin
      if (ld_cnt < 320) begin
        cap[ld_cnt] <= core_miso;
        ld_cnt      <= ld_cnt + 1;
      end else begin
        rd_idx <= rd_idx + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge; returns with resp_valid high (or the bound expired).
  task automatic run_txn(input logic [127:0] text, input logic [191:0] key,
                         input logic [127:0] ret, input int fin_delay, input bit hold_valid,
                         input bit noise, output int lat);
    int n, wc;
    bit fdone;
    req_text  = text;
    req_key   = key;
    stub_out  = ret;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (!hold_valid) req_valid = 1'b0;
    wc    = 0;
    fdone = 0;
    while (!resp_valid && lat < 2000) begin
      core_finished = 1'b0;
      if (req_ready) bad_ready++;
      if (noise && core_cs && ld_cnt < 320) core_finished = 1'b1;
      if (!fdone && !core_cs && busy && ld_cnt == 320) begin
        wc++;
        if (fin_delay != 0 && wc == fin_delay) begin
          core_finished = 1'b1;
          fdone = 1;
        end
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    core_finished = 1'b0;
  endtask

  // Holds resp_ready low for hold cycles checking stability, then completes the handshake.
  task automatic finish_resp(input int hold, input logic [127:0] exp_data, input logic exp_err);
    int changes;
    changes = 0;
    for (int i = 0; i < hold; i++) begin
      if (!resp_valid || resp_data !== exp_data || resp_err !== exp_err) changes++;
      @(posedge clk);
      @(negedge clk);
    end
    check("resp_stable", 320'(changes), 320'(0));
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("ready_after_hs", 320'(req_ready), 320'(1));
    check("valid_after_hs", 320'(resp_valid), 320'(0));
  endtask

  localparam logic [191:0] KeyA   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] TextA  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CiphA  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] Alt    = 128'h55555555555555555555555555555555;

  initial begin
    int lat, acc0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_text = '0;
    req_key = '0;
    resp_ready = 1'b0;
    core_finished = 1'b0;
    stub_out = '0;
    bad_ready = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 320'(req_ready), 320'(0));
    check("rst_busy", 320'(busy), 320'(0));
    check("rst_cs", 320'(core_cs), 320'(0));
    check("rst_miso", 320'(core_miso), 320'(0));
    check("rst_resp_valid", 320'(resp_valid), 320'(0));
    check("rst_resp_data", 320'(resp_data), 320'(0));
    check("rst_resp_err", 320'(resp_err), 320'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 320'(req_ready), 320'(1));

    // Encrypt vector; finished on the first WAIT cycle
    bad_ready = 0;
    run_txn(TextA, KeyA, CiphA, 1, 1'b0, 1'b0, lat);
    check("enc_latency", 320'(lat), 320'(450));
    check("enc_loaded", cap, {KeyA, TextA});
    check("enc_load_cycles", 320'(ld_cnt), 320'(320));
    check("enc_data", 320'(resp_data), 320'(CiphA));
    check("enc_err", 320'(resp_err), 320'(0));
    check("enc_no_ready_busy", 320'(bad_ready), 320'(0));
    finish_resp(0, CiphA, 1'b0);

    // Decrypt vector; finished pulsed during LOAD must be ignored
    run_txn(CiphA, KeyA, TextA, 3, 1'b0, 1'b1, lat);
    check("dec_latency", 320'(lat), 320'(452));
    check("dec_loaded", cap, {KeyA, CiphA});
    check("dec_data", 320'(resp_data), 320'(TextA));
    check("dec_read_cycles", 320'(rd_idx), 320'(128));
    finish_resp(0, TextA, 1'b0);

    // Watchdog: core never finishes
    run_txn(TextA, KeyA, CiphA, 0, 1'b0, 1'b0, lat);
    check("to_latency", 320'(lat), 320'(1 + 320 + TO));
    check("to_err", 320'(resp_err), 320'(1));
    check("to_data", 320'(resp_data), 320'(0));
    check("to_no_read", 320'(rd_idx), 320'(0));
    finish_resp(2, 128'h0, 1'b1);

    // Alternating 1,0 response with a slow requester
    run_txn(TextA, KeyA, Alt, 5, 1'b0, 1'b0, lat);
    check("alt_latency", 320'(lat), 320'(454));
    check("alt_data", 320'(resp_data), 320'(Alt));
    finish_resp(50, Alt, 1'b0);
    check("alt_idle", 320'(busy), 320'(0));

    // req_valid held high across two transactions
    acc0 = acc_cnt;
    bad_ready = 0;
    run_txn(TextA, KeyA, CiphA, 2, 1'b1, 1'b0, lat);
    finish_resp(3, CiphA, 1'b0);
    run_txn(TextA, KeyA, Alt, 2, 1'b1, 1'b0, lat);
    req_valid = 1'b0;
    check("hold_accepts_mid", 320'(acc_cnt - acc0), 320'(2));
    check("hold_no_ready_busy", 320'(bad_ready), 320'(0));
    check("hold_second_data", 320'(resp_data), 320'(Alt));
    finish_resp(0, Alt, 1'b0);
    check("hold_accepts_end", 320'(acc_cnt - acc0), 320'(2));

    // Reset in the middle of LOAD
    req_text = TextA;
    req_key = KeyA;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 200 && ld_cnt != 100; i++) @(negedge clk);
    check("midrst_reached", 320'(ld_cnt), 320'(100));
    rst = 1'b1;
    #1;
    check("midrst_cs", 320'(core_cs), 320'(0));
    check("midrst_valid", 320'(resp_valid), 320'(0));
    check("midrst_busy", 320'(busy), 320'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(TextA, KeyA, CiphA, 1, 1'b0, 1'b0, lat);
    check("after_rst_latency", 320'(lat), 320'(450));
    check("after_rst_data", 320'(resp_data), 320'(CiphA));
    finish_resp(0, CiphA, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
